mem_responder: RTL and testbench

- Memory-side responder for the 8080 core's load/store/fetch requests: serves byte-addressed byte and 16-bit little-endian word accesses over a valid/ready request and response handshake.
- Storage is split into even and odd byte banks, so an unaligned word costs the same as an aligned one.
- Sits between the core's fetch/execute memory port and the backing RAM; replaces direct word-indexed access with a byte-exact interface.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_byte_bank.sv | 23 ++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the byte-exact memory responder.
package mem_pkg;
  localparam int unsigned DEF_ADDR_W     = 16;
  localparam logic [15:0] DEF_PRINT_ADDR = 16'hFFFF;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_byte_bank.sv
// Synchronous byte-wide RAM, single read/write port, registered read data.
module mem_byte_bank #(
  parameter int unsigned IDX_W = 15
) (
  input  logic             clk,
  input  logic             en,
  input  logic             wen,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] r_mem [2**IDX_W];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) r_mem[addr] <= wdata;
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Byte/word memory responder over split even/odd byte banks with valid/ready handshakes.
// Optional console output at PRINT_ADDR when MEM_PRINT_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned          ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]    PRINT_ADDR = DEF_PRINT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic              req_size,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
`ifdef MEM_PRINT_EN
  output logic [15:0]       rsp_data,
  output logic              print_valid,
  output logic [7:0]        print_char
`else
  output logic [15:0]       rsp_data
`endif
);
  localparam int unsigned IDX_W = ADDR_W - 1;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic              r_size;
  logic [15:0]       r_wdata;

  logic              w_bank_en;
  logic              w_odd, w_word;
  logic [IDX_W-1:0]  w_idx, w_idx_p1;
  logic [IDX_W-1:0]  w_even_addr;
  logic              w_even_wen, w_odd_wen;
  logic [7:0]        w_even_wdata, w_odd_wdata;
  logic [7:0]        w_even_rdata, w_odd_rdata;
  logic [7:0]        w_lo, w_hi;
  logic              w_print_hit, w_mask_lo, w_mask_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_wdata <= '0;
    end else if (r_state == IDLE && req_valid) begin
      r_addr  <= req_addr;
      r_wen   <= req_wen;
      r_size  <= req_size;
      r_wdata <= req_wdata;
    end
  end

  assign w_odd    = r_addr[0];
  assign w_word   = (r_size == SIZE_WORD);
  assign w_idx    = r_addr[ADDR_W-1:1];
  assign w_idx_p1 = w_idx + 1'b1;

`ifdef MEM_PRINT_EN
  logic [ADDR_W-1:0] w_addr_p1;
  logic              r_print_valid;
  logic [7:0]        r_print_char;

  assign w_addr_p1   = r_addr + 1'b1;
  assign w_print_hit = r_wen && (r_addr == PRINT_ADDR);
  assign w_mask_lo   = (r_addr == PRINT_ADDR);
  assign w_mask_hi   = w_word && (w_addr_p1 == PRINT_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_print_valid <= 1'b0;
      r_print_char  <= '0;
    end else begin
      r_print_valid <= (r_state == ACCESS) && w_print_hit;
      if ((r_state == ACCESS) && w_print_hit) r_print_char <= r_wdata[7:0];
    end
  end

  assign print_valid = r_print_valid;
  assign print_char  = r_print_char;
`else
  assign w_print_hit = 1'b0;
  assign w_mask_lo   = 1'b0;
  assign w_mask_hi   = 1'b0;
`endif

  // Odd-address words spill their high byte into the next even slot; the print byte is never stored.
  assign w_even_addr  = (w_odd && w_word) ? w_idx_p1 : w_idx;
  assign w_even_wen   = r_wen && (w_word || !w_odd) && !(w_print_hit && !w_odd);
  assign w_odd_wen    = r_wen && (w_word ||  w_odd) && !(w_print_hit &&  w_odd);
  assign w_even_wdata = w_odd ? r_wdata[15:8] : r_wdata[7:0];
  assign w_odd_wdata  = w_odd ? r_wdata[7:0]  : r_wdata[15:8];

  mem_byte_bank #(.IDX_W(IDX_W)) u_even (
    .clk   (clk),
    .en    (w_bank_en),
    .wen   (w_even_wen),
    .addr  (w_even_addr),
    .wdata (w_even_wdata),
    .rdata (w_even_rdata)
  );

  mem_byte_bank #(.IDX_W(IDX_W)) u_odd (
    .clk   (clk),
    .en    (w_bank_en),
    .wen   (w_odd_wen),
    .addr  (w_idx),
    .wdata (w_odd_wdata),
    .rdata (w_odd_rdata)
  );

  assign w_lo = w_mask_lo ? 8'h00 : (w_odd ? w_odd_rdata  : w_even_rdata);
  assign w_hi = w_mask_hi ? 8'h00 : (w_odd ? w_even_rdata : w_odd_rdata);

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    w_bank_en = (r_state == ACCESS);
    rsp_data  = '0;
    if (r_state == RESP && !r_wen)
      rsp_data = {(w_word ? w_hi : 8'h00), w_lo};
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected responses, negedge monitor checks them.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic        req_size = 1'b0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
`ifdef MEM_PRINT_EN
  logic        print_valid;
  logic [7:0]  print_char;
  int          n_print = 0;
  logic [7:0]  last_char = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  mem_responder #(.ADDR_W(16), .PRINT_ADDR(16'hFFFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wen     (req_wen),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
`ifdef MEM_PRINT_EN
    .rsp_data    (rsp_data),
    .print_valid (print_valid),
    .print_char  (print_char)
`else
    .rsp_data    (rsp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %h expected no response", rsp_data);
      end else begin
        chk(name_q.pop_front(), {16'h0, rsp_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

`ifdef MEM_PRINT_EN
  always @(negedge clk) begin
    if (print_valid) begin
      n_print++;
      last_char = print_char;
    end
  end
`endif

  task automatic wait_accept(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_accept"}, {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk({nm, "_drain"}, exp_q.size(), 32'h0);
  endtask

  task automatic txn(input string nm, input logic [15:0] a, input logic w, input logic sz,
                     input logic [15:0] wd, input logic [15:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_wen   = w;
    req_size  = sz;
    req_wdata = wd;
    wait_accept(nm);
    #1;
    req_valid = 1'b0;
    chk({nm, "_lat_access"}, {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk({nm, "_lat_resp"}, {31'h0, rsp_valid}, 32'h1);
    wait_empty(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_data",  {16'h0, rsp_data},  32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    txn("wb_0010",   16'h0010, 1'b1, 1'b0, 16'h5AA5, 16'h0000);
    txn("rb_0010",   16'h0010, 1'b0, 1'b0, 16'h0000, 16'h00A5);
    txn("ww_0021",   16'h0021, 1'b1, 1'b1, 16'hBEEF, 16'h0000);
    txn("rb_0021",   16'h0021, 1'b0, 1'b0, 16'h0000, 16'h00EF);
    txn("rb_0022",   16'h0022, 1'b0, 1'b0, 16'h0000, 16'h00BE);
    txn("rw_0021",   16'h0021, 1'b0, 1'b1, 16'h0000, 16'hBEEF);
    txn("ww_0040",   16'h0040, 1'b1, 1'b1, 16'hCAFE, 16'h0000);
    txn("rw_0040",   16'h0040, 1'b0, 1'b1, 16'h0000, 16'hCAFE);
    txn("rb_0041",   16'h0041, 1'b0, 1'b0, 16'h0000, 16'h00CA);
    txn("wb_0041",   16'h0041, 1'b1, 1'b0, 16'hEE77, 16'h0000);
    txn("rw_0040b",  16'h0040, 1'b0, 1'b1, 16'h0000, 16'h77FE);
    txn("ww_ffff",   16'hFFFF, 1'b1, 1'b1, 16'h1234, 16'h0000);
`ifdef MEM_PRINT_EN
    txn("rw_ffff",   16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h1200);
`else
    txn("rw_ffff",   16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h1234);
`endif
    txn("rb_0000",   16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0012);

    // Back-pressure: response held, a second request waits behind it.
    rsp_ready = 1'b0;
    exp_q.push_back(16'h00A5);
    name_q.push_back("hold_rd1");
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    req_wen   = 1'b0;
    req_size  = 1'b0;
    wait_accept("hold_rd1");
    #1;
    req_addr = 16'h0022;
    exp_q.push_back(16'h00BE);
    name_q.push_back("hold_rd2");
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_rsp_data",  {16'h0, rsp_data},  32'h0000_00A5);
      chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("hold_back_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 chk("hold_second_acc", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b0;
    wait_empty("hold");

    // Reset during ACCESS of a read: no response, memory intact.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 16'h0021;
    req_wen   = 1'b0;
    req_size  = 1'b1;
    wait_accept("rst_rd");
    #1 req_valid = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 chk("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    txn("rw_0021_post_rst", 16'h0021, 1'b0, 1'b1, 16'h0000, 16'hBEEF);
    txn("rb_0010_post_rst", 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h00A5);

`ifdef MEM_PRINT_EN
    n_print = 0;
    txn("wb_print", 16'hFFFF, 1'b1, 1'b0, 16'h0048, 16'h0000);
    repeat (3) @(negedge clk);
    chk("print_count", n_print, 32'h1);
    chk("print_char",  {24'h0, last_char}, 32'h48);
    txn("rb_print", 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
`endif

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
